// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
//
// Responder end of the sdram_top user burst interface, backed by on-chip block
// RAM. It reproduces the sdram_top timing seen by initiators: the init delay,
// the req->ack latency and, optionally, the refresh stalls.
//
// Optional feature macro: REFRESH_EN. When it is defined, a free-running
// counter raises a refresh request every REF_INTERVAL cycles. The FSM serves
// that request in IDLE with a REF_CYCLES ack-free stall. When it is not
// defined, there is no refresh state and no refresh counter.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   sdram_wr_req     write burst request; held high until the first wr_ack
//   sdram_rd_req     read burst request; held high until the first rd_ack
//   sys_wraddr       write start word address, sampled at accept
//   sys_rdaddr       read start word address, sampled at accept
//   sdwr_byte        write burst length in words, sampled at accept
//   sdrd_byte        read burst length in words, sampled at accept
//   sys_data_in      write data, taken on each edge while wr_ack is high
//   sdram_wr_ack     high for exactly N consecutive cycles per write burst
//   sdram_rd_ack     high for exactly N consecutive cycles per read burst
//   sys_data_out     read data, valid while rd_ack is high; otherwise holds
//   sdram_init_done  rises once the init delay has elapsed and stays high

module sdram_burst_responder #(
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned INIT_CYCLES  = 200,
    parameter int unsigned ACK_DELAY    = 3,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_CYCLES   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_wr_req,
    input  logic        sdram_rd_req,
    input  logic [22:0] sys_wraddr,
    input  logic [22:0] sys_rdaddr,
    input  logic [8:0]  sdwr_byte,
    input  logic [8:0]  sdrd_byte,
    input  logic [15:0] sys_data_in,
    output logic        sdram_wr_ack,
    output logic        sdram_rd_ack,
    output logic [15:0] sys_data_out,
    output logic        sdram_init_done
);

    localparam int unsigned InitW = $clog2(INIT_CYCLES + 1);

`ifdef REFRESH_EN
    typedef enum logic [2:0] {
        StInit, StIdle, StWrWait, StRdWait, StWrBurst, StRdBurst, StRefresh
    } state_e;
`else
    typedef enum logic [2:0] {
        StInit, StIdle, StWrWait, StRdWait, StWrBurst, StRdBurst
    } state_e;
`endif

    state_e            state_q;
    logic [InitW-1:0]  init_cnt_q;
    logic [15:0]       dly_q;       // shared by the ack delay and the refresh stall
    logic [MEM_AW-1:0] addr_q;
    logic [8:0]        remain_q;    // acks still to give, including the current one

    logic [15:0] mem [2**MEM_AW];

    // Address bits above MEM_AW are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sys_wraddr[22:MEM_AW], sys_rdaddr[22:MEM_AW]};

`ifdef REFRESH_EN
    localparam int unsigned RefW = $clog2(REF_INTERVAL + 1);

    logic [RefW-1:0] ref_cnt_q;
    logic            ref_pend_q;
`else
    logic unused_ref_cfg;
    assign unused_ref_cfg = ^{REF_INTERVAL, REF_CYCLES};
`endif

    // Length 0 is served as one word; anything above 256 is clamped to 256.
    function automatic logic [8:0] clamp_len(input logic [8:0] raw);
        if (raw == 9'd0) begin
            return 9'd1;
        end else if (raw > 9'd256) begin
            return 9'd256;
        end else begin
            return raw;
        end
    endfunction

    // The RAM is never reset. A reset forces state_q out of StWrBurst at once,
    // so a burst that is aborted writes nothing more.
    always_ff @(posedge clk) begin
        if (state_q == StWrBurst) begin
            mem[addr_q] <= sys_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StInit;
            init_cnt_q      <= '0;
            dly_q           <= '0;
            addr_q          <= '0;
            remain_q        <= '0;
            sdram_wr_ack    <= 1'b0;
            sdram_rd_ack    <= 1'b0;
            sys_data_out    <= '0;
            sdram_init_done <= 1'b0;
`ifdef REFRESH_EN
            ref_cnt_q       <= '0;
            ref_pend_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StInit: begin
                    if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
                        state_q         <= StIdle;
                        sdram_init_done <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + InitW'(1);
                    end
                end

                StIdle: begin
`ifdef REFRESH_EN
                    if (ref_pend_q) begin
                        state_q <= StRefresh;
                        dly_q   <= 16'(REF_CYCLES - 1);
                    end else
`endif
                    if (sdram_wr_req) begin
                        state_q  <= StWrWait;
                        addr_q   <= sys_wraddr[MEM_AW-1:0];
                        remain_q <= clamp_len(sdwr_byte);
                        dly_q    <= 16'(ACK_DELAY - 1);
                    end else if (sdram_rd_req) begin
                        state_q  <= StRdWait;
                        addr_q   <= sys_rdaddr[MEM_AW-1:0];
                        remain_q <= clamp_len(sdrd_byte);
                        dly_q    <= 16'(ACK_DELAY - 1);
                    end
                end

                StWrWait: begin
                    if (dly_q == '0) begin
                        state_q      <= StWrBurst;
                        sdram_wr_ack <= 1'b1;
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end

                StRdWait: begin
                    if (dly_q == '0) begin
                        // Word 0 is fetched here, so it is valid in the first ack cycle.
                        state_q      <= StRdBurst;
                        sdram_rd_ack <= 1'b1;
                        sys_data_out <= mem[addr_q];
                        addr_q       <= addr_q + MEM_AW'(1);
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end

                StWrBurst: begin
                    addr_q <= addr_q + MEM_AW'(1);
                    if (remain_q == 9'd1) begin
                        state_q      <= StIdle;
                        sdram_wr_ack <= 1'b0;
                    end else begin
                        remain_q <= remain_q - 9'd1;
                    end
                end

                StRdBurst: begin
                    if (remain_q == 9'd1) begin
                        // The last word stays on sys_data_out after the burst.
                        state_q      <= StIdle;
                        sdram_rd_ack <= 1'b0;
                    end else begin
                        sys_data_out <= mem[addr_q];
                        addr_q       <= addr_q + MEM_AW'(1);
                        remain_q     <= remain_q - 9'd1;
                    end
                end

`ifdef REFRESH_EN
                StRefresh: begin
                    if (dly_q == '0) begin
                        state_q    <= StIdle;
                        ref_pend_q <= 1'b0;
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end
`endif

                default: state_q <= StInit;
            endcase

`ifdef REFRESH_EN
            // Placed after the FSM so that a new tick wins over a clear in the same cycle.
            if (ref_cnt_q == RefW'(REF_INTERVAL - 1)) begin
                ref_cnt_q  <= '0;
                ref_pend_q <= 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q + RefW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
`timescale 1ns/1ps

module tb_sdram_burst_responder;

    localparam int unsigned MemAw       = 10;
    localparam int unsigned MemWords    = 1 << MemAw;
    localparam int unsigned InitCycles  = 200;
    localparam int unsigned AckDelay    = 3;
    localparam int unsigned RefInterval = 50;
    localparam int unsigned RefCycles   = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_wr_req = 1'b0;
    logic        sdram_rd_req = 1'b0;
    logic [22:0] sys_wraddr = '0;
    logic [22:0] sys_rdaddr = '0;
    logic [8:0]  sdwr_byte = '0;
    logic [8:0]  sdrd_byte = '0;
    logic [15:0] sys_data_in = '0;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic [15:0] sys_data_out;
    logic        sdram_init_done;

    always #5 clk = ~clk;

    sdram_burst_responder #(
        .MEM_AW       (MemAw),
        .INIT_CYCLES  (InitCycles),
        .ACK_DELAY    (AckDelay),
        .REF_INTERVAL (RefInterval),
        .REF_CYCLES   (RefCycles)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sys_wraddr      (sys_wraddr),
        .sys_rdaddr      (sys_rdaddr),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .sys_data_in     (sys_data_in),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sys_data_out    (sys_data_out),
        .sdram_init_done (sdram_init_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_ack_cnt = 0;
    int rd_ack_cnt = 0;
    int long_lat = 0;
    bit overlap = 1'b0;

    logic [15:0] model_mem [MemWords];
    logic [15:0] wr_data_q [$];   // words to hand out while wr_ack is high
    logic [15:0] rd_exp_q  [$];   // scoreboard of expected read words

    typedef struct {
        bit          is_wr;
        logic [22:0] addr;
        logic [8:0]  raw;
        int          exp_n;
        logic [15:0] seed;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counted in edges from req assertion to first visible ack.
    task automatic check_range(input string name, input int val, input int lo, input int hi);
`ifdef REFRESH_EN
        if (val > lo) long_lat++;
        check(name, 32'(val >= lo && val <= hi), 32'd1);
`else
        if (hi < lo) $display("bad range for %s", name);
        check(name, 32'(val), 32'(lo));
`endif
    endtask

    // Write data driver: one word per ack cycle, consumed by the following edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (sdram_wr_ack && wr_data_q.size() > 0) sys_data_in = wr_data_q.pop_front();
    end

    // Monitor: ack counts, overlap detection and read scoreboard.
    initial forever begin
        @(negedge clk);
        if (sdram_wr_ack && sdram_rd_ack) overlap = 1'b1;
        if (sdram_wr_ack) wr_ack_cnt++;
        if (sdram_rd_ack) begin
            rd_ack_cnt++;
            if (rd_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_extra_ack: got data 0x%0h, expected no ack", sys_data_out);
            end else begin
                check("rd_data", 32'(sys_data_out), 32'(rd_exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic burst(input bit is_wr, input logic [22:0] addr, input logic [8:0] raw,
                         input int exp_n, input logic [15:0] seed, input string tag);
        int lat;
        int got;
        int start_cnt;
        logic [MemAw-1:0] a;
        logic [MemAw-1:0] idx;
        a = addr[MemAw-1:0];
        if (is_wr) begin
            for (int k = 0; k < exp_n; k++) begin
                idx = a + MemAw'(k);
                wr_data_q.push_back(seed + 16'(k));
                model_mem[idx] = seed + 16'(k);
            end
            start_cnt = wr_ack_cnt;
            sys_wraddr = addr;
            sdwr_byte = raw;
            sdram_wr_req = 1'b1;
        end else begin
            for (int k = 0; k < exp_n; k++) begin
                idx = a + MemAw'(k);
                rd_exp_q.push_back(model_mem[idx]);
            end
            start_cnt = rd_ack_cnt;
            sys_rdaddr = addr;
            sdrd_byte = raw;
            sdram_rd_req = 1'b1;
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(is_wr ? sdram_wr_ack : sdram_rd_ack) && lat < 2000);
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
        check_range({tag, "_latency"}, lat, AckDelay + 1, AckDelay + RefCycles + 2);
        got = 0;
        while ((is_wr ? sdram_wr_ack : sdram_rd_ack) && got < 600) begin
            tick();
            got++;
        end
        check({tag, "_contiguous"}, 32'(got), 32'(exp_n));
        check({tag, "_ack_count"},
              32'(is_wr ? wr_ack_cnt - start_cnt : rd_ack_cnt - start_cnt), 32'(exp_n));
        if (!is_wr) check({tag, "_sb_drained"}, 32'(rd_exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_init(input string tag);
        int n;
        bit saw_ack;
        n = 0;
        saw_ack = 1'b0;
        while (!sdram_init_done && n < 1000) begin
            tick();
            n++;
            if (sdram_wr_ack || sdram_rd_ack) saw_ack = 1'b1;
        end
        sdram_wr_req = 1'b0;
        check({tag, "_init_cycles"}, 32'(n), 32'(InitCycles));
        check({tag, "_no_ack_in_init"}, 32'(saw_ack), 32'd0);
    endtask

    initial begin
        int idx;
        int first_wr, last_wr, first_rd, last_rd;

        vecs[0]  = '{1'b1, 23'h000000, 9'd256, 256, 16'h0000};
        vecs[1]  = '{1'b0, 23'h000000, 9'd256, 256, 16'h0000};
        vecs[2]  = '{1'b1, 23'h0003FE, 9'd4,   4,   16'hA000};
        vecs[3]  = '{1'b0, 23'h0003FE, 9'd4,   4,   16'h0000};
        vecs[4]  = '{1'b0, 23'h000000, 9'd2,   2,   16'h0000};
        vecs[5]  = '{1'b1, 23'h000100, 9'd0,   1,   16'hB0B0};
        vecs[6]  = '{1'b0, 23'h000100, 9'd0,   1,   16'h0000};
        vecs[7]  = '{1'b1, 23'h000200, 9'd300, 256, 16'hC000};
        vecs[8]  = '{1'b0, 23'h000200, 9'd511, 256, 16'h0000};
        vecs[9]  = '{1'b1, 23'h412345, 9'd5,   5,   16'hD000};
        vecs[10] = '{1'b0, 23'h000345, 9'd5,   5,   16'h0000};

        // Reset values, then init delay with a write request held throughout INIT.
        #12;
        check("rst_wr_ack", 32'(sdram_wr_ack), 32'd0);
        check("rst_rd_ack", 32'(sdram_rd_ack), 32'd0);
        check("rst_data_out", 32'(sys_data_out), 32'd0);
        check("rst_init_done", 32'(sdram_init_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sys_wraddr = 23'h000010;
        sdwr_byte = 9'd4;
        sdram_wr_req = 1'b1;
        wait_init("boot");
        tick();
        tick();
        check("idle_after_init_wr_ack", 32'(sdram_wr_ack), 32'd0);

        for (int i = 0; i < 11; i++) begin
            burst(vecs[i].is_wr, vecs[i].addr, vecs[i].raw, vecs[i].exp_n, vecs[i].seed,
                  $sformatf("v%0d", i));
        end

        // Simultaneous requests: write first, then read of the same words.
        for (int k = 0; k < 8; k++) begin
            wr_data_q.push_back(16'h5000 + 16'(k));
            model_mem[10'h050 + 10'(k)] = 16'h5000 + 16'(k);
        end
        for (int k = 0; k < 8; k++) rd_exp_q.push_back(model_mem[10'h050 + 10'(k)]);
        sys_wraddr = 23'h000050;
        sys_rdaddr = 23'h000050;
        sdwr_byte = 9'd8;
        sdrd_byte = 9'd8;
        sdram_wr_req = 1'b1;
        sdram_rd_req = 1'b1;
        idx = 0;
        first_wr = -1;
        last_wr = -1;
        first_rd = -1;
        last_rd = -1;
        while (idx < 300) begin
            tick();
            idx++;
            if (sdram_wr_ack) begin
                if (first_wr < 0) first_wr = idx;
                last_wr = idx;
                sdram_wr_req = 1'b0;
            end
            if (sdram_rd_ack) begin
                if (first_rd < 0) first_rd = idx;
                last_rd = idx;
                sdram_rd_req = 1'b0;
            end
            if (first_rd >= 0 && !sdram_rd_ack) break;
        end
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
        check_range("sim_wr_latency", first_wr, AckDelay + 1, AckDelay + RefCycles + 2);
        check("sim_wr_len", 32'(last_wr - first_wr + 1), 32'd8);
        check("sim_rd_len", 32'(last_rd - first_rd + 1), 32'd8);
        check_range("sim_rd_gap", first_rd - last_wr, AckDelay + 2, AckDelay + RefCycles + 3);
        check("sim_sb_drained", 32'(rd_exp_q.size()), 32'd0);
        tick();
        tick();

        // Reset in the middle of a write burst, after 100 words have been written.
        for (int k = 0; k < 256; k++) wr_data_q.push_back(16'h7700 + 16'(k));
        sys_wraddr = 23'h000000;
        sdwr_byte = 9'd256;
        sdram_wr_req = 1'b1;
        idx = 0;
        do begin
            tick();
            idx++;
        end while (!sdram_wr_ack && idx < 2000);
        sdram_wr_req = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        check("pre_reset_wr_ack", 32'(sdram_wr_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_ack", 32'(sdram_wr_ack), 32'd0);
        check("async_rst_init_done", 32'(sdram_init_done), 32'd0);
        check("async_rst_data_out", 32'(sys_data_out), 32'd0);
        wr_data_q.delete();
        for (int k = 0; k < 100; k++) model_mem[k] = 16'h7700 + 16'(k);
        tick();
        tick();
        rst_n = 1'b1;
        wait_init("reinit");
        tick();
        burst(1'b0, 23'h000000, 9'd100, 100, 16'h0000, "rd_after_rst");

        check("no_ack_overlap", 32'(overlap), 32'd0);
`ifdef REFRESH_EN
        check("refresh_stalls_seen", 32'(long_lat > 0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
